sba_master: RTL and testbench

SBA_MASTER -- requirements
Module: sba_master

---
 rtl/sba_master.sv | 236 +++++++++++++++++++++++
 tb/tb_sba_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sba_master.sv
// sba_master: system bus access master behind the debug module's sbcs,
// sbaddress0 and sbdata0 registers. Turns debugger triggers into single
// bus transactions and reports status back into sbcs.
// Optional feature: define SBA_TIMEOUT_EN to build a grant/response
// timeout of TIMEOUT_CYC cycles. Without it the FSM waits indefinitely.
module sba_master #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic [ADDR_W-1:0]   sbaddress0,
   input  logic                sbaddress0_update,
   input  logic [DATA_W-1:0]   sbdata0,
   input  logic                sbdata0_update,
   input  logic                sbdata0_rd,
   input  logic [2:0]          sbaccess,
   input  logic                sbautoincrement,
   input  logic                sbreadonaddr,
   input  logic                sbreadondata,
   input  logic [2:0]          sberror_w1,
   input  logic                sbbusyerror_w1,
   output logic                sbbusy,
   output logic [2:0]          sberror,
   output logic                sbbusyerror,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_data_valid,
   output logic [ADDR_W-1:0]   addr_next,
   output logic                addr_next_wr,
   output logic                m_req,
   input  logic                m_gnt,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_strb,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_err
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   // Elaboration-time parameter sanity checks.
   if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
      $error("sba_master: DATA_W must be 32 or 64");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("sba_master: TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [1:0]          size_reg;
   logic [2:0]          sberror_next;
   logic                sbbusyerror_next;
   logic                trig_wr;
   logic                trig_rd;
   logic                trig;
   logic                gated;
   logic                idle;
   logic                size_ok;
   logic                align_ok;
   logic [2:0]          align_mask;
   logic                start;
   logic                err_size;
   logic                err_align;
   logic                busy_coll;
   logic                resp_ok;
   logic                resp_err;
   logic                tmo;
   logic [DATA_W-1:0]   wdata_rep;
   logic [NB-1:0]       strb_new;
   logic [31:0]         off_u;
   logic [31:0]         nb_u;
   logic [DATA_W-1:0]   rdata_sh;
   logic [DATA_W-1:0]   rd_mask;

   // A write trigger wins if both kinds arrive in the same cycle.
   assign trig_wr = sbdata0_update;
   assign trig_rd = (sbaddress0_update & sbreadonaddr) | (sbdata0_rd & sbreadondata);
   assign trig    = trig_wr | trig_rd;

   assign idle   = (state_reg == IDLE);
   assign gated  = (sberror != 3'd0) | sbbusyerror;
   assign sbbusy = !idle;
   assign m_req  = (state_reg == REQ);

   // Size legality and alignment of the incoming access.
   always_comb begin
      size_ok    = (sbaccess <= 3'd2) || ((sbaccess == 3'd3) && (DATA_W == 64));
      align_mask = 3'b000;
      case (sbaccess[1:0])
         2'd0:    align_mask = 3'b000;
         2'd1:    align_mask = 3'b001;
         2'd2:    align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
      align_ok = ((sbaddress0[2:0] & align_mask) == 3'b000);
   end

   assign start     = trig & idle & !gated & size_ok & align_ok;
   assign err_size  = trig & idle & !gated & !size_ok;
   assign err_align = trig & idle & !gated & size_ok & !align_ok;
   assign busy_coll = trig & !idle;
   assign resp_ok   = (state_reg == RESP) & m_rvalid & !m_err & !tmo;
   assign resp_err  = (state_reg == RESP) & m_rvalid & m_err & !tmo;

`ifdef SBA_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt_reg;

   // Cycles spent in the current access; restarts from zero while idle.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || state_reg == IDLE) begin
         tmo_cnt_reg <= '0;
      end else begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end

   // A response arriving in the last allowed cycle still completes normally.
   assign tmo = (state_reg != IDLE) && (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) &&
                !((state_reg == RESP) && m_rvalid);
`else
   assign tmo = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = REQ;
         REQ: begin
            if (tmo)        state_next = IDLE;
            else if (m_gnt) state_next = RESP;
         end
         RESP: begin
            if (tmo || m_rvalid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Write data: the low 2^size bytes of sbdata0 replicated over every lane.
   always_comb begin
      wdata_rep = sbdata0;
      case (sbaccess[1:0])
         2'd0:    wdata_rep = {NB{sbdata0[7:0]}};
         2'd1:    wdata_rep = {(NB / 2){sbdata0[15:0]}};
         2'd2:    wdata_rep = {(NB / 4){sbdata0[31:0]}};
         default: wdata_rep = sbdata0;
      endcase
   end

   // Byte enables: lanes from the byte offset up to offset + 2^size - 1.
   assign off_u = 32'(sbaddress0[OFF_W-1:0]);
   assign nb_u  = 32'd1 << sbaccess[1:0];
   for (genvar gi = 0; gi < NB; gi++) begin : g_strb
      assign strb_new[gi] = (32'(gi) >= off_u) && (32'(gi) < off_u + nb_u);
   end

   // Read data right-justified by the byte offset, zero above the access size.
   assign rdata_sh = m_rdata >> {m_addr[OFF_W-1:0], 3'b000};
   assign rd_mask  = ~({DATA_W{1'b1}} << (32'd8 << size_reg));

   // Request fields, read result and autoincrement write-back.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         m_addr        <= '0;
         m_we          <= 1'b0;
         m_wdata       <= '0;
         m_strb        <= '0;
         size_reg      <= 2'd0;
         rd_data       <= '0;
         rd_data_valid <= 1'b0;
         addr_next     <= '0;
         addr_next_wr  <= 1'b0;
      end else begin
         rd_data_valid <= 1'b0;
         addr_next_wr  <= 1'b0;
         if (start) begin
            m_addr   <= sbaddress0;
            m_we     <= trig_wr;
            m_wdata  <= wdata_rep;
            m_strb   <= strb_new;
            size_reg <= sbaccess[1:0];
         end
         if (resp_ok) begin
            if (!m_we) begin
               rd_data       <= rdata_sh & rd_mask;
               rd_data_valid <= 1'b1;
            end
            if (sbautoincrement) begin
               addr_next    <= m_addr + ADDR_W'(32'd1 << size_reg);
               addr_next_wr <= 1'b1;
            end
         end
      end
   end

   // Error status: write-1-to-clear, with a same-cycle set taking priority.
   always_comb begin
      sberror_next = sberror & ~sberror_w1;
      if (err_size)       sberror_next = 3'd4;
      else if (err_align) sberror_next = 3'd3;
      else if (resp_err)  sberror_next = 3'd2;
      else if (tmo)       sberror_next = 3'd1;
      sbbusyerror_next = sbbusyerror & !sbbusyerror_w1;
      if (busy_coll) sbbusyerror_next = 1'b1;
   end

   // Error status registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sberror     <= 3'd0;
         sbbusyerror <= 1'b0;
      end else begin
         sberror     <= sberror_next;
         sbbusyerror <= sbbusyerror_next;
      end
   end

endmodule

// File: tb/tb_sba_master.sv
// tb_sba_master: directed vectors for sba_master (DATA_W=32, ADDR_W=32),
// plus hand-written sequences for busy, clear priority, autoincrement,
// reset mid-access and (when SBA_TIMEOUT_EN is defined) the timeout.
module tb_sba_master;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [31:0] sbaddress0;
   logic        sbaddress0_update;
   logic [31:0] sbdata0;
   logic        sbdata0_update;
   logic        sbdata0_rd;
   logic [2:0]  sbaccess;
   logic        sbautoincrement;
   logic        sbreadonaddr;
   logic        sbreadondata;
   logic [2:0]  sberror_w1;
   logic        sbbusyerror_w1;
   logic        sbbusy;
   logic [2:0]  sberror;
   logic        sbbusyerror;
   logic [31:0] rd_data;
   logic        rd_data_valid;
   logic [31:0] addr_next;
   logic        addr_next_wr;
   logic        m_req;
   logic        m_gnt;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_strb;
   logic        m_rvalid;
   logic [31:0] m_rdata;
   logic        m_err;

   int n_tests = 0;
   int n_fail  = 0;

   sba_master #(
      .ADDR_W(32),
      .DATA_W(32),
      .TIMEOUT_CYC(8)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .sbaddress0(sbaddress0),
      .sbaddress0_update(sbaddress0_update),
      .sbdata0(sbdata0),
      .sbdata0_update(sbdata0_update),
      .sbdata0_rd(sbdata0_rd),
      .sbaccess(sbaccess),
      .sbautoincrement(sbautoincrement),
      .sbreadonaddr(sbreadonaddr),
      .sbreadondata(sbreadondata),
      .sberror_w1(sberror_w1),
      .sbbusyerror_w1(sbbusyerror_w1),
      .sbbusy(sbbusy),
      .sberror(sberror),
      .sbbusyerror(sbbusyerror),
      .rd_data(rd_data),
      .rd_data_valid(rd_data_valid),
      .addr_next(addr_next),
      .addr_next_wr(addr_next_wr),
      .m_req(m_req),
      .m_gnt(m_gnt),
      .m_we(m_we),
      .m_addr(m_addr),
      .m_wdata(m_wdata),
      .m_strb(m_strb),
      .m_rvalid(m_rvalid),
      .m_rdata(m_rdata),
      .m_err(m_err)
   );

   always #5 sys_clk = ~sys_clk;

   // trig: 0 = sbdata0 write, 1 = read on sbaddress0 write, 2 = read on sbdata0 read
   typedef struct {
      logic [1:0]  trig;
      logic [2:0]  acc;
      logic        ainc;
      logic        err;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        exp_req;
      logic [3:0]  exp_strb;
      logic [31:0] exp_wdata;
      logic        exp_rdv;
      logic [31:0] exp_rd;
      logic [2:0]  exp_err;
      logic        exp_anw;
      logic [31:0] exp_anext;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_trigger(input logic [1:0] trig);
      case (trig)
         2'd0: sbdata0_update = 1'b1;
         2'd1: begin sbreadonaddr = 1'b1; sbaddress0_update = 1'b1; end
         default: begin sbreadondata = 1'b1; sbdata0_rd = 1'b1; end
      endcase
   endtask

   task automatic release_trigger();
      sbdata0_update    = 1'b0;
      sbaddress0_update = 1'b0;
      sbdata0_rd        = 1'b0;
      sbreadonaddr      = 1'b0;
      sbreadondata      = 1'b0;
   endtask

   // One transaction: bus grants and responds in the first possible cycle.
   task automatic apply(input vec_t v, input string tag);
      @(negedge sys_clk);
      sbaccess        = v.acc;
      sbaddress0      = v.addr;
      sbdata0         = v.wdata;
      sbautoincrement = v.ainc;
      drive_trigger(v.trig);
      @(negedge sys_clk);
      release_trigger();
      check({tag, "_req"}, 64'(m_req), 64'(v.exp_req));
      if (v.exp_req) begin
         check({tag, "_addr"}, 64'(m_addr), 64'(v.addr));
         check({tag, "_we"}, 64'(m_we), 64'(v.trig == 2'd0));
         check({tag, "_strb"}, 64'(m_strb), 64'(v.exp_strb));
         check({tag, "_wdata"}, 64'(m_wdata), 64'(v.exp_wdata));
         m_gnt = 1'b1;
         @(negedge sys_clk);
         m_gnt    = 1'b0;
         check({tag, "_rdv_early"}, 64'(rd_data_valid), 64'd0);
         m_rvalid = 1'b1;
         m_rdata  = v.rdata;
         m_err    = v.err;
         @(negedge sys_clk);
         m_rvalid = 1'b0;
         m_err    = 1'b0;
         check({tag, "_rdv"}, 64'(rd_data_valid), 64'(v.exp_rdv));
         if (v.exp_rdv) check({tag, "_rd"}, 64'(rd_data), 64'(v.exp_rd));
         check({tag, "_anw"}, 64'(addr_next_wr), 64'(v.exp_anw));
         if (v.exp_anw) check({tag, "_anext"}, 64'(addr_next), 64'(v.exp_anext));
      end
      check({tag, "_busy"}, 64'(sbbusy), 64'd0);
      check({tag, "_sberror"}, 64'(sberror), 64'(v.exp_err));
      sberror_w1 = 3'd7;
      @(negedge sys_clk);
      sberror_w1 = 3'd0;
   endtask

   initial begin
      vec_t v;
      logic [31:0] cur;
      int req_seen;

      //          trig  acc   ainc  err   addr           wdata          rdata          req   strb     exp_wdata      rdv   exp_rd         err   anw   anext
      vecs[0]  = '{2'd1, 3'd2, 1'b0, 1'b0, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0,         1'b1, 32'hDEAD_BEEF, 3'd0, 1'b0, 32'h0};
      vecs[1]  = '{2'd0, 3'd0, 1'b0, 1'b0, 32'h0000_2003, 32'h0000_00A5, 32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0,         3'd0, 1'b0, 32'h0};
      vecs[2]  = '{2'd1, 3'd0, 1'b0, 1'b0, 32'h0000_3002, 32'h0,         32'h1122_3344, 1'b1, 4'b0100, 32'h0,         1'b1, 32'h0000_0022, 3'd0, 1'b0, 32'h0};
      vecs[3]  = '{2'd2, 3'd1, 1'b0, 1'b0, 32'h0000_3002, 32'h0,         32'h1122_3344, 1'b1, 4'b1100, 32'h0,         1'b1, 32'h0000_1122, 3'd0, 1'b0, 32'h0};
      vecs[4]  = '{2'd0, 3'd1, 1'b0, 1'b0, 32'h0000_4000, 32'h1234_BEEF, 32'h0,         1'b1, 4'b0011, 32'hBEEF_BEEF, 1'b0, 32'h0,         3'd0, 1'b0, 32'h0};
      vecs[5]  = '{2'd0, 3'd2, 1'b0, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0,         1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,         3'd0, 1'b0, 32'h0};
      vecs[6]  = '{2'd0, 3'd4, 1'b0, 1'b0, 32'h0000_5000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         3'd4, 1'b0, 32'h0};
      vecs[7]  = '{2'd1, 3'd3, 1'b0, 1'b0, 32'h0000_5000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         3'd4, 1'b0, 32'h0};
      vecs[8]  = '{2'd1, 3'd2, 1'b0, 1'b0, 32'h0000_1001, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         3'd3, 1'b0, 32'h0};
      vecs[9]  = '{2'd0, 3'd1, 1'b0, 1'b0, 32'h0000_1003, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,         3'd3, 1'b0, 32'h0};
      vecs[10] = '{2'd1, 3'd2, 1'b1, 1'b1, 32'h0000_6000, 32'h0,         32'h1234_5678, 1'b1, 4'b1111, 32'h0,         1'b0, 32'h0,         3'd2, 1'b0, 32'h0};
      vecs[11] = '{2'd1, 3'd2, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0000_ABCD, 1'b1, 4'b1111, 32'h0,         1'b1, 32'h0000_ABCD, 3'd0, 1'b1, 32'h0000_0000};
      vecs[12] = '{2'd2, 3'd0, 1'b1, 1'b0, 32'h0000_7001, 32'h0,         32'hAABB_CCDD, 1'b1, 4'b0010, 32'h0,         1'b1, 32'h0000_00CC, 3'd0, 1'b1, 32'h0000_7002};
      vecs[13] = '{2'd0, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_005A, 32'h0,         1'b1, 4'b1000, 32'h5A5A_5A5A, 1'b0, 32'h0,         3'd0, 1'b1, 32'h0000_0000};

      sys_rst = 1'b1;
      sbaddress0 = '0; sbaddress0_update = 1'b0; sbdata0 = '0; sbdata0_update = 1'b0;
      sbdata0_rd = 1'b0; sbaccess = 3'd2; sbautoincrement = 1'b0; sbreadonaddr = 1'b0;
      sbreadondata = 1'b0; sberror_w1 = 3'd0; sbbusyerror_w1 = 1'b0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;

      // Reset state.
      check("rst_busy", 64'(sbbusy), 64'd0);
      check("rst_sberror", 64'(sberror), 64'd0);
      check("rst_busyerr", 64'(sbbusyerror), 64'd0);
      check("rst_req", 64'(m_req), 64'd0);
      check("rst_rdv", 64'(rd_data_valid), 64'd0);
      check("rst_anw", 64'(addr_next_wr), 64'd0);
      check("rst_rd", 64'(rd_data), 64'd0);
      check("rst_maddr", 64'(m_addr), 64'd0);
      check("rst_wdata", 64'(m_wdata), 64'd0);
      check("rst_strb", 64'(m_strb), 64'd0);

      // Table-driven vectors.
      for (int i = 0; i < 14; i++) begin
         apply(vecs[i], $sformatf("v%0d", i));
         $display("[TB] vector %0d trig=%0d acc=%0d addr=0x%08h done", i, vecs[i].trig, vecs[i].acc, vecs[i].addr);
      end

      // Autoincrement: three halfword writes from 0x10, address written back by the bench.
      cur = 32'h10;
      sbaccess = 3'd1;
      sbautoincrement = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         sbaddress0 = cur;
         sbdata0 = 32'(i);
         sbdata0_update = 1'b1;
         @(negedge sys_clk);
         sbdata0_update = 1'b0;
         check($sformatf("ainc%0d_addr", i), 64'(m_addr), 64'(32'h10 + 32'(2 * i)));
         m_gnt = 1'b1;
         @(negedge sys_clk);
         m_gnt = 1'b0;
         m_rvalid = 1'b1;
         @(negedge sys_clk);
         m_rvalid = 1'b0;
         check($sformatf("ainc%0d_anw", i), 64'(addr_next_wr), 64'd1);
         check($sformatf("ainc%0d_anext", i), 64'(addr_next), 64'(32'h12 + 32'(2 * i)));
         cur = addr_next;
         $display("[TB] autoincrement write %0d addr_next=0x%08h", i, addr_next);
      end
      sbautoincrement = 1'b0;

      // Busy collision, with a same-cycle sbbusyerror clear losing to the set.
      @(negedge sys_clk);
      sbaccess = 3'd2; sbaddress0 = 32'h100; sbdata0 = 32'h1111_1111; sbdata0_update = 1'b1;
      @(negedge sys_clk);
      check("busy_req", 64'(m_req), 64'd1);
      sbaddress0 = 32'h200; sbdata0 = 32'h2222_2222; sbbusyerror_w1 = 1'b1;
      @(negedge sys_clk);
      sbdata0_update = 1'b0; sbbusyerror_w1 = 1'b0;
      check("busy_err_set", 64'(sbbusyerror), 64'd1);
      check("busy_req_held", 64'(m_req), 64'd1);
      check("busy_addr_held", 64'(m_addr), 64'h100);
      check("busy_wdata_held", 64'(m_wdata), 64'h1111_1111);
      m_gnt = 1'b1;
      @(negedge sys_clk);
      m_gnt = 1'b0; m_rvalid = 1'b1;
      @(negedge sys_clk);
      m_rvalid = 1'b0;
      check("busy_done", 64'(sbbusy), 64'd0);
      req_seen = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (m_req) req_seen++;
      end
      check("busy_one_access", 64'(req_seen), 64'd0);
      sbaddress0 = 32'h100; sbreadonaddr = 1'b1; sbaddress0_update = 1'b1;
      @(negedge sys_clk);
      release_trigger();
      check("busy_gated_req", 64'(m_req), 64'd0);
      check("busy_err_kept", 64'(sbbusyerror), 64'd1);
      sbbusyerror_w1 = 1'b1;
      @(negedge sys_clk);
      sbbusyerror_w1 = 1'b0;
      check("busy_err_clr", 64'(sbbusyerror), 64'd0);
      v = '{2'd1, 3'd2, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0BAD_F00D, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D, 3'd0, 1'b0, 32'h0};
      apply(v, "busy_after");
      $display("[TB] busy collision sequence done");

      // sberror: set beats a same-cycle clear, gating, then bitwise clears.
      @(negedge sys_clk);
      sbaccess = 3'd2; sbaddress0 = 32'h1002; sbreadonaddr = 1'b1; sbaddress0_update = 1'b1;
      sberror_w1 = 3'd7;
      @(negedge sys_clk);
      release_trigger(); sberror_w1 = 3'd0;
      check("prio_sberror", 64'(sberror), 64'd3);
      sbaddress0 = 32'h1000; sbreadonaddr = 1'b1; sbaddress0_update = 1'b1;
      @(negedge sys_clk);
      release_trigger();
      check("gate_req", 64'(m_req), 64'd0);
      check("gate_sberror", 64'(sberror), 64'd3);
      sberror_w1 = 3'd1;
      @(negedge sys_clk);
      check("clr_bit0", 64'(sberror), 64'd2);
      sberror_w1 = 3'd2;
      @(negedge sys_clk);
      sberror_w1 = 3'd0;
      check("clr_bit1", 64'(sberror), 64'd0);
      $display("[TB] sberror priority/clear sequence done");

      // Reset during RESP abandons the access; a late response is ignored.
      @(negedge sys_clk);
      sbaccess = 3'd2; sbaddress0 = 32'h800; sbreadonaddr = 1'b1; sbaddress0_update = 1'b1;
      @(negedge sys_clk);
      release_trigger();
      m_gnt = 1'b1;
      @(negedge sys_clk);
      m_gnt = 1'b0;
      check("rstmid_busy_before", 64'(sbbusy), 64'd1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      check("rstmid_busy", 64'(sbbusy), 64'd0);
      m_rvalid = 1'b1; m_rdata = 32'h5555_5555;
      @(negedge sys_clk);
      m_rvalid = 1'b0;
      check("rstmid_rdv", 64'(rd_data_valid), 64'd0);
      check("rstmid_sberror", 64'(sberror), 64'd0);
      $display("[TB] reset mid-access sequence done");

`ifdef SBA_TIMEOUT_EN
      // Grant never arrives: timeout after 8 cycles in REQ.
      begin
         int cyc;
         @(negedge sys_clk);
         sbaccess = 3'd2; sbaddress0 = 32'h0; sbdata0_update = 1'b1;
         @(negedge sys_clk);
         release_trigger();
         cyc = 0;
         while (sbbusy && cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
         end
         check("tmo_cycles", 64'(cyc), 64'd8);
         check("tmo_sberror", 64'(sberror), 64'd1);
         check("tmo_busy", 64'(sbbusy), 64'd0);
         $display("[TB] timeout after %0d cycles", cyc);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
